ecc_sed_decoder: RTL
====================

Name: ecc_sed_decoder

Overview:
Single-error-detect (SED) checker/decoder, directly downstream of ecc_sed_encoder.
- Consumes the encoder's 13-bit codeword: even parity bit at MSB, 12-bit data below it.
- Recomputes parity, strips the parity bit and flags any odd-weight corruption.
- Buffers results in a small FIFO with valid/ready output handshake.
- Keeps saturating word/error statistics and a sticky error flag for the status block.

Parameters:
DATA_WIDTH, 12, data payload width; codeword width is DATA_WIDTH+1
FIFO_DEPTH, 2, output buffer entries (power of two, >=2)
CNT_WIDTH, 16, width of the word and error statistics counters

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
enc_valid  input  1  codeword valid from upstream (encoder's enc_valid)
enc_codeword  input  DATA_WIDTH+1  {parity, data} from encoder
enc_ready  output  1  decoder can accept a codeword this cycle
dec_valid  output  1  decoded word available at FIFO head
dec_data  output  DATA_WIDTH  decoded payload, enc_codeword[DATA_WIDTH-1:0]
dec_error  output  1  parity mismatch on the word at FIFO head
dec_ready  input  1  downstream consumes head word when dec_valid && dec_ready
cnt_clr  input  1  synchronous clear of counters and sticky flag
word_cnt  output  CNT_WIDTH  accepted codewords, saturating
err_cnt  output  CNT_WIDTH  accepted codewords with parity error, saturating
err_sticky  output  1  set on any accepted erroneous word, held until cnt_clr/rst

Behaviour:
- Parity check: err = XOR of all DATA_WIDTH+1 codeword bits. 0 means clean; 1 means error (any odd number of bit flips). Even-weight flips are undetectable by design.
- Accept: push = enc_valid && enc_ready. enc_ready = !full, registered state only; no combinational path from dec_ready.
- FIFO stores {err, data} per entry. Read/write pointers are log2(FIFO_DEPTH)+1 bits, wrap at FIFO_DEPTH.
  - full when pointer MSBs differ and the low bits are equal.
  - empty when pointers are equal.
- Output: dec_valid = !empty; dec_data and dec_error are driven from the head entry.
  - pop = dec_valid && dec_ready.
  - Head is stable while dec_valid && !dec_ready.
- Latency: a word accepted in cycle N is visible on dec_valid/dec_data in cycle N+1 when the FIFO is empty. Throughput is 1 word/cycle with dec_ready held high.
- Simultaneous push and pop: both occur and occupancy is unchanged. When full, enc_ready=0, so a pop frees the slot only in the next cycle.
- Pop when empty and push when full are impossible by construction; pointers never move on those conditions.
- Counters, updated on push only:
  - word_cnt increments on every push.
  - err_cnt increments on push with err=1.
  - Both saturate at all-ones with no wrap.
- err_sticky is set on push with err=1.
- cnt_clr:
  - word_cnt, err_cnt and err_sticky go to 0 next cycle.
  - If a push coincides, the counters load 1 (or 0 for err_cnt when clean) and err_sticky loads that push's err.
  - FIFO contents are untouched.
- Reset, including mid-stream:
  - Pointers, counters and err_sticky are cleared; buffered words are discarded.
  - Next cycle: enc_ready=1, dec_valid=0, dec_data=0, dec_error=0, word_cnt=0, err_cnt=0, err_sticky=0.
  - Inputs are ignored during the rst cycle.

Optional Feature:
Macro ECC_SED_DEC_DROP_ON_ERR_EN.
- Defined: a pushed codeword with err=1 is counted (word_cnt, err_cnt, err_sticky) but not written to the FIFO. Only clean words reach dec_valid, and dec_error is tied to 0. enc_ready is unaffected.
- Undefined: every accepted word is forwarded with its dec_error bit, as described above.

Test Plan:
- Reset, then enc_codeword=13'h0A5C (clean) with enc_valid for 1 cycle, dec_ready=1 -> next cycle dec_valid=1, dec_data=12'hA5C, dec_error=0; word_cnt=1, err_cnt=0.
- Push 13'h0001 (odd weight) -> dec_data=12'h001, dec_error=1, err_cnt=1, err_sticky=1. With drop macro defined: no dec_valid, err_cnt=1.
- dec_ready=0, push 13'h1001, 13'h0003, 13'h0A5C back-to-back -> enc_ready drops after 2 accepts (third held). Raise dec_ready -> outputs in order 12'h001, 12'h003, 12'hA5C; word_cnt=3.
- Continuous stream with dec_ready=1 and simultaneous push/pop -> 1 word/cycle, occupancy constant, no stalls.
- Force word_cnt to all-ones via CNT_WIDTH=4 with 20 pushes -> word_cnt holds 4'hF. cnt_clr together with an erroneous push -> word_cnt=1, err_cnt=1, err_sticky=1.
- rst asserted with 2 words buffered -> next cycle dec_valid=0, enc_ready=1, all counters 0; the old words are never output.

Source files
------------

// File: rtl/ecc_sed_decoder_if.sv
// Codeword-in / decoded-word-out handshake bundle.
// slave modport is the decoder side, master the producer/consumer side.
interface ecc_sed_decoder_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  enc_valid;
  logic [DATA_WIDTH:0]   enc_codeword;
  logic                  enc_ready;
  logic                  dec_valid;
  logic [DATA_WIDTH-1:0] dec_data;
  logic                  dec_error;
  logic                  dec_ready;

  modport master (
    output enc_valid,
    output enc_codeword,
    output dec_ready,
    input  enc_ready,
    input  dec_valid,
    input  dec_data,
    input  dec_error
  );

  modport slave (
    input  enc_valid,
    input  enc_codeword,
    input  dec_ready,
    output enc_ready,
    output dec_valid,
    output dec_data,
    output dec_error
  );
endinterface

// File: rtl/ecc_sed_decoder.sv
// Even-parity SED checker with output FIFO and saturating statistics.
// Optional ECC_SED_DEC_DROP_ON_ERR_EN: count but drop erroneous words.
module ecc_sed_decoder #(
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ecc_sed_decoder_if.slave     bus,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic                 err_sticky
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + 1;

  localparam logic [AW:0] PTR_ONE =
    {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [EW-1:0] wr_entry;

  logic full;
  logic empty;
  logic err;
  logic push;
  logic pop;
  logic wr;

  logic [CNT_WIDTH-1:0] word_base;
  logic [CNT_WIDTH-1:0] err_base;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign err  = ^bus.enc_codeword;
  assign push = bus.enc_valid && bus.enc_ready;
  assign pop  = !empty && bus.dec_ready;

`ifdef ECC_SED_DEC_DROP_ON_ERR_EN
  assign wr       = push && !err;
  assign wr_entry = {1'b0, bus.enc_codeword[DATA_WIDTH-1:0]};
`else
  assign wr       = push;
  assign wr_entry = {err, bus.enc_codeword[DATA_WIDTH-1:0]};
`endif

  // Ready depends only on pointer state, never on dec_ready.
  assign bus.enc_ready = !full;
  assign bus.dec_valid = !empty;

  // Gate the head so stale storage never shows after reset.
  assign head          = mem[rd_ptr[AW-1:0]];
  assign bus.dec_data  = empty ? '0 : head[DATA_WIDTH-1:0];
  assign bus.dec_error = !empty && head[DATA_WIDTH];

  // Storage array; no reset needed, validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_entry;
    end
  end

  // Pointer update; reset discards any buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // A clear coinciding with a push restarts counting from that push.
  assign word_base = cnt_clr ? '0 : word_cnt;
  assign err_base  = cnt_clr ? '0 : err_cnt;

  // Saturating statistics and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt   <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (push && (word_base != '1)) begin
        word_cnt <= word_base + CNT_ONE;
      end else begin
        word_cnt <= word_base;
      end
      if (push && err && (err_base != '1)) begin
        err_cnt <= err_base + CNT_ONE;
      end else begin
        err_cnt <= err_base;
      end
      err_sticky <= (err_sticky && !cnt_clr) ||
                    (push && err);
    end
  end

endmodule
